// File: rtl/decoder_scan_sequencer.sv
// Select-code sequencer for a 4-to-16 decoder: walks the enabled lines of a mask,
// holding each for a programmable dwell and inserting a one-cycle blanking gap.
module decoder_scan_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        mask,
  output logic [3:0]         a,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t             state;
  logic [15:0]        mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [4:0] lowest(input logic [15:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  logic [4:0] first_in;
  logic [4:0] first_q;
  logic [4:0] next_q;

  assign first_in = lowest(mask);
  assign first_q  = lowest(mask_q);
  assign next_q   = lowest(mask_q & (16'hFFFE << a));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // stop beats a simultaneous start; an empty mask never starts a frame
          if (start && !stop && first_in[4]) begin
            mask_q  <= mask;
            dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
            a       <= first_in[3:0];
            cnt     <= DWELL_W'(1);
            valid   <= 1'b1;
            busy    <= 1'b1;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (stop) begin
            state <= IDLE;
            a     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == dwell_q) begin
            if (next_q[4]) begin
              a     <= next_q[3:0];
              valid <= 1'b0;
              state <= GAP;
            end else if (continuous && first_q[4]) begin
              a     <= first_q[3:0];
              valid <= 1'b0;
              state <= GAP;
            end else begin
              a     <= '0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
            a     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt   <= DWELL_W'(1);
            valid <= 1'b1;
            state <= ACTIVE;
          end
        end
        default: begin
          state <= IDLE;
          a     <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: a frame-schedule model checked every cycle,
// plus directed scenarios with literal expected traces.
module tb_decoder_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [7:0]  dwell;
  logic [15:0] mask;
  logic [3:0]  a;
  logic        valid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  decoder_scan_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .mask(mask), .a(a), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic       valid;
    logic       busy;
    logic       done;
  } obs_t;

  // Model: a queue of the outputs expected on each upcoming cycle of a frame.
  obs_t        plan[$];
  obs_t        exp_o = '0;
  logic        scanning = 1'b0;
  logic [15:0] lm = '0;
  int          ld = 0;
  logic        armed = 1'b0;

  function automatic obs_t mk(input int idx, input logic v, input logic b, input logic d);
    obs_t o;
    o.a = 4'(idx);
    o.valid = v;
    o.busy = b;
    o.done = d;
    return o;
  endfunction

  function automatic int lowest_line(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic void build_frame();
    bit first = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (lm[i]) begin
        if (!first) plan.push_back(mk(i, 1'b0, 1'b1, 1'b0));
        for (int j = 0; j < ld; j++) plan.push_back(mk(i, 1'b1, 1'b1, 1'b0));
        first = 1'b0;
      end
    end
  endfunction

  always @(posedge clk) begin
    armed = 1'b1;
    if (!rst_n) begin
      plan.delete();
      scanning = 1'b0;
      lm = '0;
      exp_o = '0;
    end else if (scanning && stop) begin
      plan.delete();
      scanning = 1'b0;
      exp_o = '0;
    end else if (!scanning) begin
      if (start && !stop && mask != 16'h0) begin
        lm = mask;
        ld = (dwell == 8'd0) ? 1 : int'(dwell);
        build_frame();
        scanning = 1'b1;
        exp_o = plan.pop_front();
      end else begin
        exp_o = '0;
      end
    end else if (plan.size() > 0) begin
      exp_o = plan.pop_front();
    end else if (continuous) begin
      plan.push_back(mk(lowest_line(lm), 1'b0, 1'b1, 1'b0));
      build_frame();
      exp_o = plan.pop_front();
    end else begin
      scanning = 1'b0;
      exp_o = mk(0, 1'b0, 1'b0, 1'b1);
    end
  end

  function automatic logic [6:0] cur();
    return {a, valid, busy, done};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got a=%0d valid=%b busy=%b done=%b, want a=%0d valid=%b busy=%b done=%b",
               name, got[6:3], got[2], got[1], got[0], want[6:3], want[2], want[1], want[0]);
    end
  endtask

  // Per-cycle comparison against the model, plus the two output invariants.
  always @(negedge clk) begin
    if (armed) begin
      check("model", cur(), exp_o);
      if (valid) begin
        total++;
        if (!lm[a]) begin
          bad++;
          $display("FAIL inv_mask: valid on line %0d but latched mask=%h", a, lm);
        end
      end
      if (done) begin
        total++;
        if (valid) begin
          bad++;
          $display("FAIL inv_done_valid: done=%b valid=%b", done, valid);
        end
      end
    end
  end

  task automatic sc(input string name, input logic [6:0] want);
    check(name, cur(), want);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; continuous = 1'b0;
    dwell = 8'd0; mask = 16'hFFFF;

    // reset held two cycles with start high
    repeat (2) @(negedge clk);
    check("rst_hold", cur(), {4'd0, 3'b000});
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    sc("rst_release0", {4'd0, 3'b000});
    sc("rst_release1", {4'd0, 3'b000});

    // one-shot frame over lines 0 and 2, dwell 2
    mask = 16'h0005; dwell = 8'd2; continuous = 1'b0;
    pulse_start();
    sc("os_l0_c1", {4'd0, 3'b110});
    sc("os_l0_c2", {4'd0, 3'b110});
    sc("os_gap",   {4'd2, 3'b010});
    sc("os_l2_c1", {4'd2, 3'b110});
    sc("os_l2_c2", {4'd2, 3'b110});
    sc("os_done",  {4'd0, 3'b001});
    sc("os_idle",  {4'd0, 3'b000});

    // continuous wrap over lines 0 and 15, dwell 0 treated as 1
    mask = 16'h8001; dwell = 8'd0; continuous = 1'b1;
    pulse_start();
    sc("wr_l0",    {4'd0,  3'b110});
    sc("wr_gap15", {4'd15, 3'b010});
    sc("wr_l15",   {4'd15, 3'b110});
    sc("wr_gap0",  {4'd0,  3'b010});
    check("wr_l0b", cur(), {4'd0, 3'b110});
    continuous = 1'b0;
    @(negedge clk);
    sc("wr_gap15b", {4'd15, 3'b010});
    sc("wr_l15b",   {4'd15, 3'b110});
    sc("wr_done",   {4'd0,  3'b001});
    sc("wr_idle",   {4'd0,  3'b000});

    // empty mask is ignored, then a single line 10
    mask = 16'h0000; dwell = 8'd3;
    pulse_start();
    sc("m0_a", {4'd0, 3'b000});
    sc("m0_b", {4'd0, 3'b000});
    mask = 16'h0400;
    pulse_start();
    sc("l10_c1",   {4'd10, 3'b110});
    sc("l10_c2",   {4'd10, 3'b110});
    sc("l10_c3",   {4'd10, 3'b110});
    sc("l10_done", {4'd0,  3'b001});
    sc("l10_idle", {4'd0,  3'b000});

    // start while busy ignored; stop on the final dwell cycle suppresses done
    mask = 16'h0005; dwell = 8'd2; continuous = 1'b0;
    pulse_start();
    check("sp_l0_c1", cur(), {4'd0, 3'b110});
    start = 1'b1; mask = 16'hFFFF; dwell = 8'd7;
    @(negedge clk);
    start = 1'b0;
    sc("sp_l0_c2", {4'd0, 3'b110});
    sc("sp_gap",   {4'd2, 3'b010});
    sc("sp_l2_c1", {4'd2, 3'b110});
    check("sp_l2_c2", cur(), {4'd2, 3'b110});
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    sc("sp_abort", {4'd0, 3'b000});
    sc("sp_quiet", {4'd0, 3'b000});
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    sc("ss_idle", {4'd0, 3'b000});

    // full-mask continuous scan, reset while line 7 is driven
    mask = 16'hFFFF; dwell = 8'd3; continuous = 1'b1;
    pulse_start();
    repeat (29) @(negedge clk);
    check("rs_line7", cur(), {4'd7, 3'b110});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sc("rs_cleared", {4'd0, 3'b000});
    sc("rs_after1",  {4'd0, 3'b000});
    sc("rs_after2",  {4'd0, 3'b000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
